huff_bit_packer_ctrl: RTL and testbench

// Sequencer for the 128-bit variable-length bit accumulator in the Huffman output stage.

---
 rtl/huff_pkg.sv | 25 ++
 rtl/huff_shift_acc.sv | 36 +++
 rtl/huff_bit_packer_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_huff_bit_packer_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared constants, FSM state type and code-length mask helper for the
// Huffman output-stage bit packer.
package huff_pkg;

  localparam int unsigned BUF_W  = 128;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned CODE_W = 32;
  localparam int unsigned LEN_W  = $clog2(CODE_W) + 1;
  localparam int unsigned FILL_W = $clog2(BUF_W) + 1;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    FINAL
  } state_e;

  // Mask with the low 'len' bits set, computed at accumulator width.
  function automatic logic [BUF_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [BUF_W-1:0] ones;
    ones = '1;
    if (len == '0) return '0;
    return ones >> (FILL_W'(BUF_W) - FILL_W'(len));
  endfunction

endpackage

// File: rtl/huff_shift_acc.sv
// Shift-accumulate register holding the packer bit buffer and its fill level.
// The controller supplies the fill level after any drain; this block adds the
// newly accepted code length on top of it.
module huff_shift_acc
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CODE_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [FILL_W-1:0] fill_base,
  output logic [BUF_W-1:0]  prev_data,
  output logic [FILL_W-1:0] fill
);

  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;

  assign prev_data = r_buf;
  assign fill      = r_fill;

  // Shift the masked code in at the LSB end and advance the fill level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else begin
      r_fill <= fill_base + (enable ? FILL_W'(len_in) : '0);
      if (enable) begin
        r_buf <= (r_buf << len_in) | (BUF_W'(data_in) & len_mask(len_in));
      end
    end
  end

endmodule

// File: rtl/huff_bit_packer_ctrl.sv
// Sequencer for the Huffman variable-length bit accumulator: accepts
// (code, length) beats, drains MSB-first 32-bit words and flushes a
// zero-padded final word with a valid-bit count at end of block.
module huff_bit_packer_ctrl
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [CODE_W-1:0] code_data,
  input  logic [LEN_W-1:0]  code_len,
  input  logic              code_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [LEN_W-1:0]  out_nbits,
  output logic [31:0]       total_bits,
  output logic              busy
);

  localparam logic [FILL_W-1:0] OUT_W_F     = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] READY_MAX_F = FILL_W'(BUF_W - CODE_W);

  state_e            r_state;
  state_e            w_state_next;

  logic [BUF_W-1:0]  w_buf;
  logic [FILL_W-1:0] w_fill;
  logic [FILL_W-1:0] w_fill_base;

  logic              w_accept;
  logic              w_hold_free;
  logic              w_drain;
  logic              w_final_hs;
  logic              w_load;
  logic              w_load_last;
  logic              w_mark_last;
  logic [OUT_W-1:0]  w_load_data;
  logic [LEN_W-1:0]  w_load_nbits;
  logic [FILL_W-1:0] w_drain_sh;
  logic [FILL_W-1:0] w_tail_sh;
  logic [OUT_W-1:0]  w_drain_word;
  logic [OUT_W-1:0]  w_tail_word;

  logic              r_out_valid;
  logic [OUT_W-1:0]  r_out_data;
  logic              r_out_last;
  logic [LEN_W-1:0]  r_out_nbits;
  logic [31:0]       r_total_bits;
  logic              r_busy;

  huff_shift_acc u_acc (
    .clk       (clk),
    .reset     (reset),
    .enable    (w_accept),
    .data_in   (code_data),
    .len_in    (code_len),
    .fill_base (w_fill_base),
    .prev_data (w_buf),
    .fill      (w_fill)
  );

  assign code_ready  = (r_state == RUN) && (w_fill <= READY_MAX_F);
  assign w_accept    = code_valid && code_ready;
  assign w_hold_free = !r_out_valid || out_ready;
  assign w_drain     = w_hold_free && (w_fill >= OUT_W_F);
  assign w_final_hs  = (r_state == FINAL) && r_out_valid && out_ready && r_out_last;

  // Shift amounts are guarded so fill-1 based indexing never underflows.
  assign w_drain_sh   = (w_fill >= OUT_W_F) ? (w_fill - OUT_W_F) : '0;
  assign w_tail_sh    = (w_fill <  OUT_W_F) ? (OUT_W_F - w_fill) : '0;
  assign w_drain_word = OUT_W'(w_buf >> w_drain_sh);
  assign w_tail_word  = OUT_W'(w_buf << w_tail_sh);

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign out_nbits  = r_out_nbits;
  assign total_bits = r_total_bits;
  assign busy       = r_busy;

  // Next state, holding-register load selection and post-drain fill level.
  // A block ending at fill==0 tags the word that empties the buffer; if that
  // word already sits stalled in the holding register its last flag is raised
  // in place, otherwise an empty (nbits=0) terminating word is emitted.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_data  = w_drain_word;
    w_load_nbits = LEN_W'(OUT_W);
    w_load_last  = 1'b0;
    w_mark_last  = 1'b0;
    w_fill_base  = w_drain ? (w_fill - OUT_W_F) : w_fill;
    case (r_state)
      RUN: begin
        w_load = w_drain;
        if (w_accept && code_last) begin
          if (w_drain && (w_fill == OUT_W_F) && (code_len == '0)) begin
            w_load_last  = 1'b1;
            w_state_next = FINAL;
          end else begin
            w_state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (w_drain) begin
          w_load = 1'b1;
          if (w_fill == OUT_W_F) begin
            w_load_last  = 1'b1;
            w_state_next = FINAL;
          end
        end else if (w_fill != '0) begin
          if (w_hold_free) begin
            w_load       = 1'b1;
            w_load_data  = w_tail_word;
            w_load_nbits = w_fill[LEN_W-1:0];
            w_load_last  = 1'b1;
            w_fill_base  = '0;
            w_state_next = FINAL;
          end
        end else if (w_hold_free) begin
          w_load       = 1'b1;
          w_load_data  = '0;
          w_load_nbits = '0;
          w_load_last  = 1'b1;
          w_state_next = FINAL;
        end else begin
          w_mark_last  = 1'b1;
          w_state_next = FINAL;
        end
      end
      FINAL: begin
        if (w_final_hs) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  // Output holding register; contents hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_nbits <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_last  <= w_load_last;
      r_out_nbits <= w_load_nbits;
    end else if (w_mark_last) begin
      r_out_last  <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Block bit counter and busy flag, both cleared by the final-word handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_total_bits <= '0;
      r_busy       <= 1'b0;
    end else if (w_final_hs) begin
      r_total_bits <= '0;
      r_busy       <= 1'b0;
    end else if (w_accept) begin
      r_total_bits <= r_total_bits + 32'(code_len);
      r_busy       <= 1'b1;
    end
  end

  a_len_legal: assert property (@(posedge clk) disable iff (reset)
    code_valid |-> (code_len <= LEN_W'(CODE_W)));

endmodule

// File: tb/tb_huff_bit_packer_ctrl.sv
// Directed self-checking bench for huff_bit_packer_ctrl.
module tb_huff_bit_packer_ctrl;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic        code_ready;
  logic [31:0] code_data;
  logic [5:0]  code_len;
  logic        code_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [5:0]  out_nbits;
  logic [31:0] total_bits;
  logic        busy;

  huff_bit_packer_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_data  (code_data),
    .code_len   (code_len),
    .code_last  (code_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_nbits  (out_nbits),
    .total_bits (total_bits),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] d;
    logic [5:0]  nb;
    logic        last;
    int unsigned cyc;
  } word_t;

  word_t       q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output handshake between edges.
  always @(negedge clk) begin
    word_t w;
    if (!reset && out_valid && out_ready) begin
      w.d    = out_data;
      w.nb   = out_nbits;
      w.last = out_last;
      w.cyc  = cyc;
      q.push_back(w);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic [5:0] l, input logic lst);
    int unsigned n;
    n = 0;
    code_valid = 1'b1;
    code_data  = d;
    code_len   = l;
    code_last  = lst;
    @(negedge clk);
    while (!code_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    code_valid = 1'b0;
    code_last  = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int unsigned n);
    int unsigned k;
    k = 0;
    while (q.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq(tag, 64'(q.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k;
    k = 0;
    while ((busy || out_valid) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq(tag, {62'd0, busy, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; code_valid = 1'b0; code_data = '0; code_len = '0;
    code_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_eq("rst_ready",  64'(code_ready), 64'd1);
    check_eq("rst_valid",  64'(out_valid),  64'd0);
    check_eq("rst_busy",   64'(busy),       64'd0);
    check_eq("rst_total",  64'(total_bits), 64'd0);
    check_eq("rst_last",   64'(out_last),   64'd0);

    // 1: four byte codes form one full final word
    q.delete();
    send(32'h0000_00A5, 6'd8, 1'b0);
    send(32'h0000_003C, 6'd8, 1'b0);
    send(32'h0000_00FF, 6'd8, 1'b0);
    send(32'h0000_0001, 6'd8, 1'b1);
    check_eq("t1_not_yet", 64'(out_valid), 64'd0);
    check_eq("t1_total",   64'(total_bits), 64'd32);
    @(posedge clk); #1;
    check_eq("t1_valid", 64'(out_valid), 64'd1);
    check_eq("t1_data",  64'(out_data),  64'hA53C_FF01);
    check_eq("t1_nbits", 64'(out_nbits), 64'd32);
    check_eq("t1_last",  64'(out_last),  64'd1);
    @(posedge clk); #1;
    check_eq("t1_busy_clr",  64'(busy),       64'd0);
    check_eq("t1_total_clr", 64'(total_bits), 64'd0);

    // 2: 13 five-bit codes (values 1..13, junk in the upper bits)
    q.delete();
    for (int i = 1; i <= 13; i++)
      send(32'hFFFF_FFE0 | 32'(i), 6'd5, (i == 13));
    wait_words("t2_count", 3);
    if (q.size() >= 3) begin
      check_eq("t2_w0",      64'(q[0].d),    64'h0886_4298);
      check_eq("t2_w1",      64'(q[1].d),    64'hE84A_96C6);
      check_eq("t2_w2",      64'(q[2].d),    64'h8000_0000);
      check_eq("t2_w1_nb",   64'(q[1].nb),   64'd32);
      check_eq("t2_w1_last", 64'(q[1].last), 64'd0);
      check_eq("t2_w2_nb",   64'(q[2].nb),   64'd1);
      check_eq("t2_w2_last", 64'(q[2].last), 64'd1);
    end
    wait_idle("t2_idle");

    // 3: downstream stall for 20 cycles while streaming 32-bit codes
    q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(32'hC0DE_0000 + 32'(k), 6'd32, (k == 5));
      end
      begin
        repeat (10) @(posedge clk);
        #1 check_eq("t3_hold_mid", 64'(out_data), 64'hC0DE_0000);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t3_ready_low", 64'(code_ready), 64'd0);
        check_eq("t3_valid",     64'(out_valid),  64'd1);
        check_eq("t3_hold_end",  64'(out_data),   64'hC0DE_0000);
        out_ready = 1'b1;
      end
    join
    wait_words("t3_count", 6);
    if (q.size() >= 6) begin
      for (int k = 0; k < 6; k++)
        check_eq($sformatf("t3_w%0d", k), 64'(q[k].d), 64'hC0DE_0000 + 64'(k));
      check_eq("t3_last", 64'(q[5].last), 64'd1);
    end
    wait_idle("t3_idle");

    // 4: fill parked at 96, then accept+drain every cycle
    q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(32'h4000_0000 + 32'(k), 6'd32, 1'b0);
    out_ready = 1'b1;
    send(32'h4000_0004, 6'd32, 1'b0);
    check_eq("t4_total",  64'(total_bits), 64'd160);
    check_eq("t4_ready",  64'(code_ready), 64'd1);
    for (int k = 5; k < 8; k++) send(32'h4000_0000 + 32'(k), 6'd32, (k == 7));
    wait_words("t4_count", 8);
    if (q.size() >= 8) begin
      check_eq("t4_span", 64'(q[7].cyc - q[0].cyc), 64'd7);
      check_eq("t4_w5",   64'(q[5].d), 64'h4000_0005);
      check_eq("t4_last", {62'd0, q[6].last, q[7].last}, 64'd1);
    end
    wait_idle("t4_idle");

    // 5: block ends exactly on a word boundary
    q.delete();
    send(32'h0000_AAAA, 6'd16, 1'b0);
    send(32'h0000_BBBB, 6'd16, 1'b0);
    send(32'h0000_CCCC, 6'd16, 1'b0);
    send(32'h0000_DDDD, 6'd16, 1'b1);
    wait_idle("t5_idle");
    repeat (5) @(posedge clk);
    #1 check_eq("t5_count", 64'(q.size()), 64'd2);
    if (q.size() >= 2) begin
      check_eq("t5_w0",   64'(q[0].d),  64'hAAAA_BBBB);
      check_eq("t5_w1",   64'(q[1].d),  64'hCCCC_DDDD);
      check_eq("t5_nb",   64'(q[1].nb), 64'd32);
      check_eq("t5_last", {62'd0, q[0].last, q[1].last}, 64'd1);
    end

    // 6: reset while flushing with 40 bits buffered
    q.delete();
    out_ready = 1'b0;
    send(32'h1111_1111, 6'd32, 1'b0);
    send(32'h2222_2222, 6'd32, 1'b0);
    send(32'h0000_0033, 6'd8,  1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_flush_ready", 64'(code_ready), 64'd0);
    check_eq("t6_flush_busy",  64'(busy),       64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("t6_rst_valid", 64'(out_valid),  64'd0);
    check_eq("t6_rst_busy",  64'(busy),       64'd0);
    check_eq("t6_rst_ready", 64'(code_ready), 64'd1);
    check_eq("t6_rst_total", 64'(total_bits), 64'd0);
    q.delete();
    out_ready = 1'b1;
    send(32'hFFFF_FF12, 6'd8,  1'b0);
    send(32'h0034_5678, 6'd24, 1'b1);
    wait_words("t6_count", 1);
    if (q.size() >= 1) begin
      check_eq("t6_data", 64'(q[0].d),    64'h1234_5678);
      check_eq("t6_last", 64'(q[0].last), 64'd1);
      check_eq("t6_nb",   64'(q[0].nb),   64'd32);
    end
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
